// File: rtl/seq_tx_pkg.sv
// Shared state encoding, counter width and default frame constants for the 1011 serial transmitter.
// The GAP state exists only when SEQ_TX_GAP_EN is defined.
package seq_tx_pkg;

    localparam int unsigned WIDTH_DEFAULT   = 4;
    localparam int unsigned GAP_DEFAULT     = 2;
    localparam logic [15:0] PATTERN_DEFAULT = 16'b1011;

    // Bit index (WIDTH-1 <= 15), gap length (<= 15) and frame count all fit in 4 bits
    localparam int unsigned CTR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
`ifdef SEQ_TX_GAP_EN
        ,
        ST_GAP  = 2'd3
`endif
    } state_e;

endpackage

// File: rtl/seq_tx_if.sv
// Control and serial-output bundle of the transmitter; master drives requests, slave is the transmitter.
// Clock and reset stay outside the bundle as plain ports.
interface seq_tx_if;
    logic       start;
    logic [3:0] reps;
    logic       abort;
    logic       sig;
    logic       sig_valid;
    logic       busy;
    logic       done;

    modport master (
        output start, reps, abort,
        input  sig, sig_valid, busy, done
    );

    modport slave (
        input  start, reps, abort,
        output sig, sig_valid, busy, done
    );
endinterface

// File: rtl/seq_tx_ctr.sv
// Loadable down-counter with zero flag; load has priority and decrement saturates at zero.
// Used for the pattern bit index and, when compiled in, the inter-frame gap.
module seq_tx_ctr #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/seq_tx_1011.sv
// Burst transmitter of a WIDTH-bit PATTERN (MSB first), reps frames per start; Moore outputs only.
// SEQ_TX_GAP_EN inserts GAP idle-zero bits between frames; without it frames go back-to-back.
module seq_tx_1011
    import seq_tx_pkg::*;
#(
    parameter logic [15:0] PATTERN = PATTERN_DEFAULT,
    parameter int unsigned WIDTH   = WIDTH_DEFAULT,
    parameter int unsigned GAP     = GAP_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    seq_tx_if.slave      bus
);

    if ((WIDTH < 2) || (WIDTH > 16)) begin : g_bad_width
        $error("seq_tx_1011: WIDTH must be in 2..16");
    end
    if ((GAP < 1) || (GAP > 15)) begin : g_bad_gap
        $error("seq_tx_1011: GAP must be in 1..15");
    end

    localparam logic [CTR_W-1:0] IDX_LOAD = CTR_W'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CTR_W-1:0] rem_q;
    logic [CTR_W-1:0] rem_d;

    logic             idx_load;
    logic             idx_dec;
    logic             idx_zero;
    logic [CTR_W-1:0] idx;

    seq_tx_ctr #(.W(CTR_W)) u_idx_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (idx_load),
        .load_val (IDX_LOAD),
        .dec      (idx_dec),
        .cnt      (idx),
        .zero     (idx_zero)
    );

`ifdef SEQ_TX_GAP_EN
    localparam logic [CTR_W-1:0] GAP_LOAD = CTR_W'(GAP - 1);

    logic             gap_load;
    logic             gap_dec;
    logic             gap_zero;
    logic [CTR_W-1:0] gap_cnt_unused;

    seq_tx_ctr #(.W(CTR_W)) u_gap_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (GAP_LOAD),
        .dec      (gap_dec),
        .cnt      (gap_cnt_unused),
        .zero     (gap_zero)
    );
`endif

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        idx_load = 1'b0;
        idx_dec  = 1'b0;
`ifdef SEQ_TX_GAP_EN
        gap_load = 1'b0;
        gap_dec  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // abort beats start when both arrive in IDLE
                if (bus.start && !bus.abort) begin
                    if (bus.reps != '0) begin
                        rem_d    = bus.reps;
                        idx_load = 1'b1;
                        state_d  = ST_SEND;
                    end else begin
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_SEND: begin
                if (bus.abort) begin
                    rem_d   = '0;
                    state_d = ST_IDLE;
                end else if (idx_zero) begin
                    if (rem_q != '0) begin
                        rem_d = rem_q - 1'b1;
                    end
                    if (rem_q <= CTR_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
`ifdef SEQ_TX_GAP_EN
                        gap_load = 1'b1;
                        state_d  = ST_GAP;
`else
                        idx_load = 1'b1;
`endif
                    end
                end else begin
                    idx_dec = 1'b1;
                end
            end
`ifdef SEQ_TX_GAP_EN
            ST_GAP: begin
                if (bus.abort) begin
                    rem_d   = '0;
                    state_d = ST_IDLE;
                end else if (gap_zero) begin
                    idx_load = 1'b1;
                    state_d  = ST_SEND;
                end else begin
                    gap_dec = 1'b1;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    assign bus.sig_valid = (state_q == ST_SEND);
    assign bus.sig       = (state_q == ST_SEND) && PATTERN[idx];
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_tx_1011.sv
// Scoreboard bench for seq_tx_1011: expected {sig,sig_valid,busy,done} per cycle is queued at stimulus time.
// Works in both builds; the expected gap length follows SEQ_TX_GAP_EN.
module tb_seq_tx_1011;

    localparam logic [3:0] PAT = 4'b1011;
    localparam int         W   = 4;
`ifdef SEQ_TX_GAP_EN
    localparam int         GAP_N = 2;
`else
    localparam int         GAP_N = 0;
`endif

    logic clk = 1'b0;
    logic rst;

    seq_tx_if bus();

    seq_tx_1011 #(
        .PATTERN (16'b1011),
        .WIDTH   (4),
        .GAP     (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [3:0]  exp_q[$];
    int          busy_cnt;
    int          done_cnt;
    int          valid_cnt;
    int          hits;
    logic [3:0]  det;
    logic [31:0] stream;
    string       cur;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s.%s obs=%0h exp=%0h", cur, tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        busy_cnt  = 0;
        done_cnt  = 0;
        valid_cnt = 0;
        hits      = 0;
        det       = 4'b0000;
        stream    = '0;
    endtask

    // One frame = W pattern bits, frames separated by GAP_N idle bits, then one done cycle
    task automatic push_burst(input int n);
        for (int f = 0; f < n; f++) begin
            for (int b = W - 1; b >= 0; b--) begin
                exp_q.push_back({PAT[b], 1'b1, 1'b1, 1'b0});
            end
            if (f < n - 1) begin
                for (int g = 0; g < GAP_N; g++) begin
                    exp_q.push_back(4'b0010);
                end
            end
        end
        exp_q.push_back(4'b0011);
    endtask

    task automatic cycle();
        logic [3:0] obs;
        logic [3:0] exp;
        @(posedge clk);
        @(negedge clk);
        obs = {bus.sig, bus.sig_valid, bus.busy, bus.done};
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0000;
        check_eq("out", {28'd0, obs}, {28'd0, exp});
        if (bus.busy) begin
            busy_cnt++;
            stream = {stream[30:0], bus.sig};
        end
        if (bus.done)      done_cnt++;
        if (bus.sig_valid) valid_cnt++;
        det = {det[2:0], bus.sig};
        if (det == 4'b1011) hits++;
    endtask

    task automatic drain(input int extra);
        int guard;
        guard = 0;
        while ((exp_q.size() > 0) && (guard < 200)) begin
            cycle();
            guard++;
        end
        check_eq("drained", exp_q.size(), 0);
        repeat (extra) cycle();
    endtask

    task automatic start_burst(input logic [3:0] n);
        bus.start = 1'b1;
        bus.reps  = n;
        push_burst(int'(n));
        cycle();
        bus.start = 1'b0;
    endtask

    logic [31:0] exp_stream;

    initial begin
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.reps  = 4'd0;
        bus.abort = 1'b0;
        #1 rst = 1'b1;
        #2;
        cur = "reset";
        check_eq("outs", {28'd0, bus.sig, bus.sig_valid, bus.busy, bus.done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cycle();

        // single frame
        cur = "single";
        clear_stats();
        start_burst(4'd1);
        drain(2);
        check_eq("busy", busy_cnt, 5);
        check_eq("done", done_cnt, 1);
        exp_stream = 32'b10110;
        check_eq("stream", stream & 32'h1f, exp_stream);
        check_eq("hits", hits, 1);

        // three-frame burst with a start/reps change mid-burst that must be ignored
        cur = "burst3";
        clear_stats();
        start_burst(4'd3);
        repeat (3) cycle();
        bus.start = 1'b1;
        bus.reps  = 4'd7;
        cycle();
        bus.start = 1'b0;
        bus.reps  = 4'd0;
        drain(2);
        check_eq("busy", busy_cnt, 3 * W + 2 * GAP_N + 1);
        check_eq("done", done_cnt, 1);
        check_eq("hits", hits, 3);
`ifdef SEQ_TX_GAP_EN
        exp_stream = 32'b10110010110010110;
        check_eq("stream", stream & 32'h1ffff, exp_stream);
`else
        exp_stream = 32'b1011101110110;
        check_eq("stream", stream & 32'h1fff, exp_stream);
`endif

        // zero reps
        cur = "zero";
        clear_stats();
        start_burst(4'd0);
        drain(2);
        check_eq("busy", busy_cnt, 1);
        check_eq("done", done_cnt, 1);
        check_eq("valid", valid_cnt, 0);

        // abort on the third SEND cycle, then restart from IDLE
        cur = "abort";
        clear_stats();
        start_burst(4'd2);
        repeat (2) cycle();
        exp_q.delete();
        bus.abort = 1'b1;
        cycle();
        bus.abort = 1'b0;
        check_eq("done_none", done_cnt, 0);
        check_eq("busy3", busy_cnt, 3);
        start_burst(4'd1);
        drain(2);
        check_eq("done_new", done_cnt, 1);
        check_eq("busy_new", busy_cnt, 3 + 5);

        // abort together with start in IDLE stays IDLE
        cur = "abort_idle";
        clear_stats();
        bus.abort = 1'b1;
        bus.start = 1'b1;
        bus.reps  = 4'd1;
        repeat (2) cycle();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        repeat (2) cycle();
        check_eq("busy", busy_cnt, 0);
        check_eq("done", done_cnt, 0);

        // reset mid-burst (in GAP when compiled in), then start sampled on the first edge after release
        cur = "rst_mid";
        clear_stats();
        start_burst(4'd4);
        repeat (W) cycle();
        rst = 1'b1;
        #1;
        check_eq("async", {28'd0, bus.sig, bus.sig_valid, bus.busy, bus.done}, 32'd0);
        exp_q.delete();
        repeat (2) cycle();
        check_eq("done_none", done_cnt, 0);
        clear_stats();
        rst = 1'b0;
        start_burst(4'd1);
        drain(2);
        check_eq("busy", busy_cnt, 5);
        check_eq("done", done_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
